// File: rtl/sar_stream_ctrl.sv
// Command-driven scheduler: averages 2**AvgLog2 SAR conversions and streams the result as a big-endian UART frame.
// Optional macro SAR_STREAM_CKSUM_EN appends a third checksum byte to every frame.
module sar_stream_ctrl #(
  parameter int Width    = 10,
  parameter int AvgLog2  = 2,
  parameter int PeriodMs = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       cmd_i,
  input  logic             cmd_valid_i,
  input  logic             tick_1ms_i,
  input  logic [Width-1:0] result_i,
  input  logic             eosar_i,
  input  logic             eot_i,
  output logic             start_sar_o,
  output logic             start_tx_o,
  output logic [7:0]       tx_data_o,
  output logic             clear_cmd_o,
  output logic             busy_o,
  output logic             cont_o
);

  localparam int AccW    = Width + AvgLog2;
  localparam int CntW    = AvgLog2 + 1;
  localparam int CntLast = (1 << AvgLog2) - 1;
  localparam int PerW    = (PeriodMs > 1) ? $clog2(PeriodMs) : 1;
  localparam int PerLast = (PeriodMs > 0) ? (PeriodMs - 1) : 0;

  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_X = 8'h58;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_CONV_START  = 4'd1,
    ST_CONV_WAIT   = 4'd2,
    ST_SEND_HI     = 4'd3,
    ST_WAIT_HI     = 4'd4,
    ST_SEND_LO     = 4'd5,
    ST_WAIT_LO     = 4'd6,
`ifdef SAR_STREAM_CKSUM_EN
    ST_SEND_CK     = 4'd8,
    ST_WAIT_CK     = 4'd9,
`endif
    ST_PERIOD_WAIT = 4'd7
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_cont;
  logic              w_cont_nxt;
  logic [AccW-1:0]   r_acc;
  logic [CntW-1:0]   r_cnt;
  logic [PerW-1:0]   r_per_cnt;
  logic [15:0]       r_avg;
  logic              r_start_sar;
  logic              r_start_tx;
  logic [7:0]        r_tx_data;
  logic              r_clear_cmd;
  logic              r_busy;

  logic              w_cmd_s;
  logic              w_cmd_c;
  logic              w_cmd_x;
  logic              w_acc_clr;
  logic [AccW-1:0]   w_acc_sum;
  logic [AccW-1:0]   w_acc_shr;
  logic [15:0]       w_avg_new;

`ifdef SAR_STREAM_CKSUM_EN
  function automatic logic [7:0] f_cksum(input logic [15:0] avg);
    return avg[15:8] ^ avg[7:0] ^ 8'hA5;
  endfunction
`endif

  function automatic state_t f_after_frame(input logic cont);
    if (!cont) begin
      return ST_IDLE;
    end else if (PeriodMs == 0) begin
      return ST_CONV_START;
    end else begin
      return ST_PERIOD_WAIT;
    end
  endfunction

  assign w_cmd_s   = cmd_valid_i && (cmd_i == CMD_S);
  assign w_cmd_c   = cmd_valid_i && (cmd_i == CMD_C);
  assign w_cmd_x   = cmd_valid_i && (cmd_i == CMD_X);
  assign w_acc_sum = r_acc + AccW'(result_i);
  assign w_acc_shr = w_acc_sum >> AvgLog2;
  assign w_avg_new = 16'(w_acc_shr);
  // every fresh measurement starts from an empty accumulator
  assign w_acc_clr = (w_state_nxt == ST_CONV_START) && (r_state != ST_CONV_WAIT);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and continuous-mode flag
  always_comb begin
    w_state_nxt = r_state;
    w_cont_nxt  = r_cont & ~w_cmd_x;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_s || w_cmd_c) begin
          w_state_nxt = ST_CONV_START;
          w_cont_nxt  = w_cmd_c;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CONV_START: w_state_nxt = ST_CONV_WAIT;
      ST_CONV_WAIT: begin
        if (eosar_i) begin
          w_state_nxt = (r_cnt == CntW'(CntLast)) ? ST_SEND_HI : ST_CONV_START;
        end else begin
          w_state_nxt = ST_CONV_WAIT;
        end
      end
      ST_SEND_HI: w_state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (eot_i) begin
          w_state_nxt = ST_SEND_LO;
        end else begin
          w_state_nxt = ST_WAIT_HI;
        end
      end
      ST_SEND_LO: w_state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (eot_i) begin
`ifdef SAR_STREAM_CKSUM_EN
          w_state_nxt = ST_SEND_CK;
`else
          w_state_nxt = f_after_frame(w_cont_nxt);
`endif
        end else begin
          w_state_nxt = ST_WAIT_LO;
        end
      end
`ifdef SAR_STREAM_CKSUM_EN
      ST_SEND_CK: w_state_nxt = ST_WAIT_CK;
      ST_WAIT_CK: begin
        if (eot_i) begin
          w_state_nxt = f_after_frame(w_cont_nxt);
        end else begin
          w_state_nxt = ST_WAIT_CK;
        end
      end
`endif
      ST_PERIOD_WAIT: begin
        if (w_cmd_x) begin
          w_state_nxt = ST_IDLE;
        end else if (tick_1ms_i && (r_per_cnt == PerW'(PerLast))) begin
          w_state_nxt = ST_CONV_START;
        end else begin
          w_state_nxt = ST_PERIOD_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cont_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cont      <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_per_cnt   <= '0;
      r_avg       <= 16'd0;
      r_start_sar <= 1'b0;
      r_start_tx  <= 1'b0;
      r_tx_data   <= 8'd0;
      r_clear_cmd <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cont      <= w_cont_nxt;
      r_clear_cmd <= cmd_valid_i;
      r_start_sar <= (w_state_nxt == ST_CONV_START);
      r_busy      <= (w_state_nxt != ST_IDLE);
`ifdef SAR_STREAM_CKSUM_EN
      r_start_tx  <= (w_state_nxt == ST_SEND_HI) || (w_state_nxt == ST_SEND_LO) ||
                     (w_state_nxt == ST_SEND_CK);
`else
      r_start_tx  <= (w_state_nxt == ST_SEND_HI) || (w_state_nxt == ST_SEND_LO);
`endif
      if (w_acc_clr) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if ((r_state == ST_CONV_WAIT) && eosar_i) begin
        r_acc <= w_acc_sum;
        r_cnt <= r_cnt + CntW'(1);
      end
      if (w_state_nxt != ST_PERIOD_WAIT) begin
        r_per_cnt <= '0;
      end else if (tick_1ms_i) begin
        r_per_cnt <= r_per_cnt + PerW'(1);
      end
      // the high byte leaves with the same edge that latches the average
      if (w_state_nxt == ST_SEND_HI) begin
        r_avg     <= w_avg_new;
        r_tx_data <= w_avg_new[15:8];
      end else if (w_state_nxt == ST_SEND_LO) begin
        r_tx_data <= r_avg[7:0];
`ifdef SAR_STREAM_CKSUM_EN
      end else if (w_state_nxt == ST_SEND_CK) begin
        r_tx_data <= f_cksum(r_avg);
`endif
      end
    end
  end

  assign start_sar_o = r_start_sar;
  assign start_tx_o  = r_start_tx;
  assign tx_data_o   = r_tx_data;
  assign clear_cmd_o = r_clear_cmd;
  assign busy_o      = r_busy;
  assign cont_o      = r_cont;

endmodule

// File: tb/tb_sar_stream_ctrl.sv
// Self-checking bench for sar_stream_ctrl: SAR/UART responders plus an averaging reference model.
module tb_sar_stream_ctrl;

  localparam int NCONV = 4;
`ifdef SAR_STREAM_CKSUM_EN
  localparam int FRAME = 3;
`else
  localparam int FRAME = 2;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] cmd_i = 8'd0;
  logic       cmd_valid_i = 1'b0;
  logic       tick_1ms_i = 1'b0;
  logic [9:0] result_i;
  logic       eosar_i;
  logic       eot_i;
  logic       start_sar_o, start_tx_o, clear_cmd_o, busy_o, cont_o;
  logic [7:0] tx_data_o;

  logic       eosar_r = 1'b0, eosar_m = 1'b0, eot_r = 1'b0, eot_m = 1'b0;
  logic [9:0] result_r = 10'd0, result_m = 10'd0;
  assign eosar_i  = eosar_r | eosar_m;
  assign result_i = eosar_m ? result_m : result_r;
  assign eot_i    = eot_r | eot_m;

  int         n_vec = 0;
  int         n_err = 0;
  int         starts = 0;
  int         eot_cnt = 0;
  int         tx_unstable = 0;
  int         tx_min = 1;
  logic       busy_after_eot = 1'b0;
  logic       sar_auto = 1'b1;
  logic       tx_auto = 1'b1;
  logic       sar_fixed = 1'b0;
  int         fixed_vals[4];
  int         fixed_idx = 0;
  int         sar_q[$];
  logic [7:0] tx_q[$];

  sar_stream_ctrl #(.Width(10), .AvgLog2(2), .PeriodMs(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i),
    .tick_1ms_i(tick_1ms_i), .result_i(result_i), .eosar_i(eosar_i), .eot_i(eot_i),
    .start_sar_o(start_sar_o), .start_tx_o(start_tx_o), .tx_data_o(tx_data_o),
    .clear_cmd_o(clear_cmd_o), .busy_o(busy_o), .cont_o(cont_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (start_sar_o) starts = starts + 1;
  end

  // SAR converter model: answers each start after 1..4 cycles
  initial begin : sar_resp
    forever begin
      @(negedge clk_i);
      while (start_sar_o && sar_auto) begin
        int d;
        int v;
        d = $urandom_range(1, 4);
        repeat (d) @(negedge clk_i);
        if (sar_fixed) begin
          v = fixed_vals[fixed_idx % 4];
          fixed_idx++;
        end else begin
          v = $urandom_range(0, 1023);
        end
        sar_q.push_back(v);
        result_r = 10'(v);
        eosar_r  = 1'b1;
        @(negedge clk_i);
        eosar_r  = 1'b0;
        result_r = 10'($urandom);
      end
    end
  end

  // UART transmitter model: logs each byte, checks it is held, then ends the transfer
  initial begin : tx_resp
    forever begin
      @(negedge clk_i);
      while (start_tx_o && tx_auto) begin
        logic [7:0] b;
        int d;
        b = tx_data_o;
        tx_q.push_back(b);
        d = $urandom_range(tx_min, tx_min + 3);
        repeat (d) begin
          @(negedge clk_i);
          if (tx_data_o !== b) tx_unstable++;
        end
        eot_r = 1'b1;
        @(negedge clk_i);
        eot_r = 1'b0;
        busy_after_eot = busy_o;
        eot_cnt++;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] model_avg();
    int s = 0;
    foreach (sar_q[i]) s += sar_q[i];
    return 16'(s / NCONV);
  endfunction

  function automatic logic [7:0] exp_byte(input logic [15:0] a, input int i);
    case (i)
      0:       return a[15:8];
      1:       return a[7:0];
      default: return a[15:8] ^ a[7:0] ^ 8'hA5;
    endcase
  endfunction

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk_i);
    cmd_i = b;
    cmd_valid_i = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_i = 8'($urandom);
  endtask

  task automatic wait_eots(input int target, output bit ok);
    for (int t = 0; t < 800 && eot_cnt < target; t++) @(negedge clk_i);
    ok = (eot_cnt >= target);
  endtask

  task automatic do_measure(input logic [7:0] c, output bit ok, output logic first_start);
    int e0;
    sar_q.delete();
    tx_q.delete();
    e0 = eot_cnt;
    send_cmd(c);
    first_start = start_sar_o;
    wait_eots(e0 + FRAME, ok);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_vec++;
    if ({start_sar_o, start_tx_o, clear_cmd_o, busy_o, cont_o} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got %b exp 00000",
               {start_sar_o, start_tx_o, clear_cmd_o, busy_o, cont_o});
    end
    n_vec++;
    if (tx_data_o !== 8'h00) begin
      n_err++;
      $display("FAIL reset_txdata got %h exp 00", tx_data_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_single();
    bit ok;
    logic fs;
    int s0;
    sar_fixed = 1'b1;
    fixed_vals = '{100, 101, 102, 103};
    fixed_idx = 0;
    tx_unstable = 0;
    s0 = starts;
    do_measure(8'h53, ok, fs);
    n_vec++;
    if (fs !== 1'b1) begin n_err++; $display("FAIL single_latency start_sar got %b exp 1", fs); end
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL single_timeout eots got %0d exp %0d", tx_q.size(), FRAME); end
    n_vec++;
    if (starts - s0 !== NCONV) begin n_err++; $display("FAIL single_starts got %0d exp %0d", starts - s0, NCONV); end
    n_vec++;
    if (tx_q.size() !== FRAME) begin
      n_err++;
      $display("FAIL single_len got %0d exp %0d", tx_q.size(), FRAME);
    end else begin
      for (int i = 0; i < FRAME; i++) begin
        n_vec++;
        if (tx_q[i] !== exp_byte(16'd101, i)) begin
          n_err++;
          $display("FAIL single_byte%0d got %h exp %h", i, tx_q[i], exp_byte(16'd101, i));
        end
      end
    end
    n_vec++;
    if (busy_after_eot !== 1'b0) begin n_err++; $display("FAIL single_busy_after_eot got %b exp 0", busy_after_eot); end
    n_vec++;
    if (tx_unstable !== 0) begin n_err++; $display("FAIL single_tx_stable got %0d changes exp 0", tx_unstable); end
  endtask

  task automatic test_max();
    bit ok;
    logic fs;
    logic [7:0] exp3[3];
    exp3 = '{8'h03, 8'hFF, 8'h59};
    sar_fixed = 1'b1;
    fixed_vals = '{1023, 1023, 1023, 1023};
    fixed_idx = 0;
    do_measure(8'h53, ok, fs);
    n_vec++;
    if (!ok || tx_q.size() !== FRAME) begin
      n_err++;
      $display("FAIL max_len got %0d exp %0d", tx_q.size(), FRAME);
    end else begin
      for (int i = 0; i < FRAME; i++) begin
        n_vec++;
        if (tx_q[i] !== exp3[i]) begin
          n_err++;
          $display("FAIL max_byte%0d got %h exp %h", i, tx_q[i], exp3[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic fs;
    int s0;
    logic [15:0] a;
    sar_fixed = 1'b0;
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk_i);
      s0 = starts;
      do_measure(8'h53, ok, fs);
      a = model_avg();
      n_vec++;
      if (!ok || sar_q.size() !== NCONV || starts - s0 !== NCONV || tx_q.size() !== FRAME) begin
        n_err++;
        $display("FAIL random_shape run%0d conv %0d starts %0d bytes %0d exp %0d/%0d/%0d",
                 r, sar_q.size(), starts - s0, tx_q.size(), NCONV, NCONV, FRAME);
      end else begin
        for (int i = 0; i < FRAME; i++) begin
          n_vec++;
          if (tx_q[i] !== exp_byte(a, i)) begin
            n_err++;
            $display("FAIL random_byte run%0d b%0d got %h exp %h", r, i, tx_q[i], exp_byte(a, i));
          end
        end
      end
    end
  endtask

  task automatic test_ignored();
    bit ok;
    logic fs;
    int s0;
    logic [15:0] a;
    s0 = starts;
    send_cmd(8'h41);
    n_vec++;
    if ({clear_cmd_o, busy_o, start_sar_o, cont_o} !== 4'b1000) begin
      n_err++;
      $display("FAIL unknown_cmd clear/busy/start/cont got %b exp 1000",
               {clear_cmd_o, busy_o, start_sar_o, cont_o});
    end
    @(negedge clk_i);
    n_vec++;
    if (clear_cmd_o !== 1'b0) begin n_err++; $display("FAIL clear_width got %b exp 0", clear_cmd_o); end
    repeat (4) @(negedge clk_i);
    n_vec++;
    if (starts !== s0) begin n_err++; $display("FAIL unknown_starts got %0d exp %0d", starts - s0, 0); end
    sar_fixed = 1'b0;
    sar_q.delete();
    tx_q.delete();
    s0 = starts;
    begin
      int e0;
      e0 = eot_cnt;
      send_cmd(8'h53);
      send_cmd(8'h53);
      n_vec++;
      if ({clear_cmd_o, cont_o, busy_o} !== 3'b101) begin
        n_err++;
        $display("FAIL busy_S clear/cont/busy got %b exp 101", {clear_cmd_o, cont_o, busy_o});
      end
      send_cmd(8'h43);
      n_vec++;
      if (cont_o !== 1'b0) begin n_err++; $display("FAIL busy_C cont got %b exp 0", cont_o); end
      wait_eots(e0 + FRAME, ok);
    end
    a = model_avg();
    n_vec++;
    if (!ok || starts - s0 !== NCONV || tx_q.size() !== FRAME) begin
      n_err++;
      $display("FAIL busy_cmd_shape starts %0d bytes %0d exp %0d/%0d", starts - s0, tx_q.size(), NCONV, FRAME);
    end else begin
      for (int i = 0; i < FRAME; i++) begin
        n_vec++;
        if (tx_q[i] !== exp_byte(a, i)) begin
          n_err++;
          $display("FAIL busy_cmd_byte%0d got %h exp %h", i, tx_q[i], exp_byte(a, i));
        end
      end
    end
    n_vec++;
    if (busy_after_eot !== 1'b0) begin n_err++; $display("FAIL busy_cmd_idle got %b exp 0", busy_after_eot); end
  endtask

  task automatic test_continuous();
    bit ok;
    int e0;
    int s1;
    logic [15:0] a;
    sar_fixed = 1'b0;
    sar_q.delete();
    tx_q.delete();
    e0 = eot_cnt;
    send_cmd(8'h43);
    n_vec++;
    if ({cont_o, start_sar_o} !== 2'b11) begin
      n_err++;
      $display("FAIL cont_start cont/start got %b exp 11", {cont_o, start_sar_o});
    end
    for (int f = 0; f < 2; f++) begin
      wait_eots(e0 + (f + 1) * FRAME, ok);
      a = model_avg();
      n_vec++;
      if (!ok || tx_q.size() !== FRAME || sar_q.size() !== NCONV) begin
        n_err++;
        $display("FAIL cont_frame%0d bytes %0d conv %0d exp %0d/%0d", f, tx_q.size(), sar_q.size(), FRAME, NCONV);
      end else begin
        for (int i = 0; i < FRAME; i++) begin
          n_vec++;
          if (tx_q[i] !== exp_byte(a, i)) begin
            n_err++;
            $display("FAIL cont_frame%0d_byte%0d got %h exp %h", f, i, tx_q[i], exp_byte(a, i));
          end
        end
      end
      n_vec++;
      if (busy_after_eot !== 1'b1) begin n_err++; $display("FAIL cont_period_busy got %b exp 1", busy_after_eot); end
      sar_q.delete();
      tx_q.delete();
      if (f == 0) begin
        for (int k = 1; k <= 3; k++) begin
          repeat ($urandom_range(1, 3)) @(negedge clk_i);
          n_vec++;
          if (start_sar_o !== 1'b0) begin n_err++; $display("FAIL period_early before tick%0d got 1 exp 0", k); end
          tick_1ms_i = 1'b1;
          @(negedge clk_i);
          tick_1ms_i = 1'b0;
          n_vec++;
          if (start_sar_o !== (k == 3)) begin
            n_err++;
            $display("FAIL period_start after tick%0d got %b exp %b", k, start_sar_o, (k == 3));
          end
        end
      end
    end
    tick_1ms_i = 1'b1;
    @(negedge clk_i);
    tick_1ms_i = 1'b0;
    send_cmd(8'h58);
    n_vec++;
    if ({busy_o, cont_o, clear_cmd_o} !== 3'b001) begin
      n_err++;
      $display("FAIL period_stop busy/cont/clear got %b exp 001", {busy_o, cont_o, clear_cmd_o});
    end
    s1 = starts;
    for (int k = 0; k < 12; k++) begin
      tick_1ms_i = k[0];
      @(negedge clk_i);
    end
    tick_1ms_i = 1'b0;
    n_vec++;
    if (starts !== s1 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL period_stop_quiet starts %0d busy %b exp 0/0", starts - s1, busy_o);
    end
  endtask

  task automatic test_stop_in_wait_hi();
    bit ok;
    int e0;
    int s0;
    logic [15:0] a;
    tx_min = 5;
    sar_q.delete();
    tx_q.delete();
    e0 = eot_cnt;
    s0 = starts;
    send_cmd(8'h43);
    for (int t = 0; t < 400 && tx_q.size() == 0; t++) @(negedge clk_i);
    send_cmd(8'h58);
    n_vec++;
    if ({cont_o, busy_o} !== 2'b01) begin
      n_err++;
      $display("FAIL stop_hi cont/busy got %b exp 01", {cont_o, busy_o});
    end
    wait_eots(e0 + FRAME, ok);
    a = model_avg();
    n_vec++;
    if (!ok || tx_q.size() !== FRAME || starts - s0 !== NCONV) begin
      n_err++;
      $display("FAIL stop_hi_shape bytes %0d starts %0d exp %0d/%0d", tx_q.size(), starts - s0, FRAME, NCONV);
    end else begin
      for (int i = 0; i < FRAME; i++) begin
        n_vec++;
        if (tx_q[i] !== exp_byte(a, i)) begin
          n_err++;
          $display("FAIL stop_hi_byte%0d got %h exp %h", i, tx_q[i], exp_byte(a, i));
        end
      end
    end
    n_vec++;
    if (busy_after_eot !== 1'b0) begin n_err++; $display("FAIL stop_hi_idle got %b exp 0", busy_after_eot); end
    tx_min = 1;
  endtask

  task automatic test_x_with_final_eot();
    int s1;
    int t;
    tx_auto = 1'b0;
    send_cmd(8'h43);
    for (int i = 0; i < FRAME; i++) begin
      t = 0;
      while (!start_tx_o && t < 400) begin
        @(negedge clk_i);
        t++;
      end
      n_vec++;
      if (!start_tx_o) begin n_err++; $display("FAIL xeot_wait byte%0d got no start_tx exp start_tx", i); end
      repeat ($urandom_range(1, 3)) @(negedge clk_i);
      if (i == FRAME - 1) begin
        cmd_i = 8'h58;
        cmd_valid_i = 1'b1;
      end
      eot_m = 1'b1;
      @(negedge clk_i);
      eot_m = 1'b0;
      cmd_valid_i = 1'b0;
    end
    n_vec++;
    if ({busy_o, cont_o} !== 2'b00) begin
      n_err++;
      $display("FAIL xeot_idle busy/cont got %b exp 00", {busy_o, cont_o});
    end
    s1 = starts;
    repeat (5) begin
      tick_1ms_i = 1'b1;
      @(negedge clk_i);
      tick_1ms_i = 1'b0;
      @(negedge clk_i);
    end
    n_vec++;
    if (starts !== s1) begin n_err++; $display("FAIL xeot_quiet starts got %0d exp 0", starts - s1); end
    tx_auto = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic fs;
    int s0;
    sar_auto = 1'b0;
    s0 = starts;
    send_cmd(8'h53);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if ({start_sar_o, start_tx_o, clear_cmd_o, busy_o, cont_o, tx_data_o} !== 13'd0) begin
      n_err++;
      $display("FAIL midreset_outputs got %b exp 0",
               {start_sar_o, start_tx_o, clear_cmd_o, busy_o, cont_o, tx_data_o});
    end
    rst_i = 1'b0;
    result_m = 10'h3FF;
    eosar_m = 1'b1;
    @(negedge clk_i);
    eosar_m = 1'b0;
    eot_m = 1'b1;
    @(negedge clk_i);
    eot_m = 1'b0;
    repeat (4) @(negedge clk_i);
    n_vec++;
    if (busy_o !== 1'b0 || start_tx_o !== 1'b0 || starts - s0 !== 1) begin
      n_err++;
      $display("FAIL midreset_late busy %b start_tx %b starts %0d exp 0/0/1", busy_o, start_tx_o, starts - s0);
    end
    sar_auto = 1'b1;
    sar_fixed = 1'b1;
    fixed_vals = '{200, 201, 202, 204};
    fixed_idx = 0;
    do_measure(8'h53, ok, fs);
    n_vec++;
    if (!ok || tx_q.size() !== FRAME) begin
      n_err++;
      $display("FAIL midreset_len got %0d exp %0d", tx_q.size(), FRAME);
    end else begin
      for (int i = 0; i < FRAME; i++) begin
        n_vec++;
        if (tx_q[i] !== exp_byte(16'h00C9, i)) begin
          n_err++;
          $display("FAIL midreset_byte%0d got %h exp %h", i, tx_q[i], exp_byte(16'h00C9, i));
        end
      end
    end
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_max();
    test_random();
    test_ignored();
    test_continuous();
    test_stop_in_wait_hi();
    test_x_with_final_eot();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sar_stream_ctrl.md
Name: sar_stream_ctrl

Overview:
- Command-driven scheduler that sequences the SAR converter and UART transmitter in the unic_cass top.
- A single UART command byte selects one of three operations:
  - 'S' (0x53) runs one averaged measurement.
  - 'C' (0x43) runs averaged measurements continuously at a fixed millisecond period.
  - 'X' (0x58) stops continuous mode.
- Each measurement is 2**AvgLog2 SAR conversions, accumulated and averaged, then sent as a 2-byte big-endian frame over the transmitter.

Parameters:
- Width, 10, SAR result width; legal range 1..16.
- AvgLog2, 2, log2 of conversions per measurement; legal range 0..6.
- PeriodMs, 10, number of tick_1ms_i pulses between frames in continuous mode; 0 means back-to-back.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- cmd_i  in  8  received command byte.
- cmd_valid_i  in  1  one-cycle pulse; cmd_i is valid this cycle (receiver eor).
- tick_1ms_i  in  1  one-cycle 1 ms pacing pulse.
- result_i  in  Width  SAR result; valid while eosar_i is high.
- eosar_i  in  1  one-cycle end-of-conversion pulse.
- eot_i  in  1  one-cycle end-of-transmission pulse.
- start_sar_o  out  1  one-cycle conversion start.
- start_tx_o  out  1  one-cycle transmit start.
- tx_data_o  out  8  byte to transmit.
- clear_cmd_o  out  1  one-cycle pulse that clears the command buffer.
- busy_o  out  1  high whenever state != IDLE.
- cont_o  out  1  continuous mode active.

Behaviour:
- Clock and reset: single clock clk_i. rst_i is synchronous and active-high and is the only reset.
- Reset values: all outputs 0; state IDLE; accumulator, conversion counter and period counter 0; cont flag 0.
- Reset mid-operation aborts at once: no further pulses; pending eosar_i or eot_i is ignored.
- States: IDLE, CONV_START, CONV_WAIT, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, PERIOD_WAIT.
- Command decode (any state, when cmd_valid_i = 1):
  - clear_cmd_o pulses the next cycle for every byte, recognised or not.
  - 'S' in IDLE goes to CONV_START; accumulator and count cleared.
  - 'C' in IDLE sets cont and goes to CONV_START.
  - 'C' or 'S' outside IDLE is ignored.
  - 'X' clears cont in any state. A frame in progress completes, then the block goes to IDLE.
  - Other bytes are ignored.
- Latency: cmd_valid_i sampled in cycle n; start_sar_o high in cycle n+1.
- Conversion loop:
  - CONV_START asserts start_sar_o for exactly 1 cycle, then goes to CONV_WAIT.
  - CONV_WAIT: on eosar_i, acc += result_i (zero-extended) and count++.
  - If count reaches 2**AvgLog2, go to SEND_HI; otherwise go to CONV_START.
  - eosar_i outside CONV_WAIT is ignored.
- Arithmetic:
  - acc width is Width+AvgLog2.
  - avg = acc >> AvgLog2 (truncating), zero-extended to 16 bits.
  - The final add happens before avg is latched. No overflow is possible by construction.
- Transmit:
  - SEND_HI drives tx_data_o = avg[15:8] and pulses start_tx_o for 1 cycle.
  - WAIT_HI holds tx_data_o until eot_i.
  - SEND_LO and WAIT_LO do the same for avg[7:0].
  - tx_data_o stays stable from the start_tx_o cycle through eot_i.
  - eot_i outside WAIT_* states is ignored.
- After WAIT_LO sees eot_i:
  - If cont = 1, go to PERIOD_WAIT; otherwise go to IDLE.
  - PERIOD_WAIT counts tick_1ms_i pulses. When the count equals PeriodMs, go to CONV_START and reset acc, count and the period counter.
  - PeriodMs = 0 skips PERIOD_WAIT.
  - 'X' during PERIOD_WAIT goes to IDLE the next cycle.
- Simultaneous events: cmd_valid_i with 'X' in the same cycle as the final eot_i gives IDLE, never PERIOD_WAIT.
- busy_o = (state != IDLE). cont_o mirrors the cont flag.

Optional Feature:
- Macro: SAR_STREAM_CKSUM_EN.
- When defined:
  - Add states SEND_CK and WAIT_CK after WAIT_LO.
  - Transmit a third byte equal to avg[15:8] XOR avg[7:0] XOR 0xA5, using the same handshake.
  - The frame is 3 bytes.
- When undefined: the states do not exist, frames are 2 bytes, and behaviour is exactly as above.

Test Plan:
- Reset, then 'S' with AvgLog2 = 2 and SAR returning 100, 101, 102, 103: four start_sar_o pulses; avg = 101; tx bytes 0x00 then 0x65; busy_o low after second eot_i.
- Width = 10, single result 0x3FF with AvgLog2 = 0: bytes 0x03, 0xFF. With SAR_STREAM_CKSUM_EN, third byte 0x03^0xFF^0xA5 = 0x59.
- 'C' with PeriodMs = 3: frame sent; next start_sar_o exactly 1 cycle after the 3rd tick_1ms_i following the second eot_i. 'X' sent during PERIOD_WAIT: IDLE next cycle, no further start_sar_o.
- 'X' during WAIT_HI of a continuous frame: both bytes still sent, then IDLE; cont_o falls the cycle after 'X'.
- Unknown byte 0x41 in IDLE, and 'S' while busy: clear_cmd_o pulses, no state change, no extra conversions.
- rst_i asserted during CONV_WAIT, then a late eosar_i: all outputs 0, state IDLE, acc 0; next 'S' produces a correct fresh average.
